// File: rtl/reg_arb_pkg.sv
// Shared constants for the register-bus arbiter: FSM encoding, requester indices, default geometry.
package reg_arb_pkg;

    localparam int unsigned ADDR_W_DEF    = 6;
    localparam int unsigned DATA_W_DEF    = 8;
    localparam int unsigned LAST_ADDR_DEF = 32'h1F;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    localparam logic REQ_SPI = 1'b0;
    localparam logic REQ_SEQ = 1'b1;

endpackage

// File: rtl/reg_arb_pick.sv
// Combinational winner selection between the SPI decoder and the internal sequencer.
// REG_ARB_RR_EN selects round-robin on collisions; otherwise requester 0 always wins.
module reg_arb_pick
    import reg_arb_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic win_o
);

`ifdef REG_ARB_RR_EN
    // On a collision the requester that did not win last time goes next.
    always_comb begin
        win_o = REQ_SPI;
        if (req0_i && req1_i) begin
            win_o = ~last_i;
        end else if (req1_i) begin
            win_o = REQ_SEQ;
        end
    end
`else
    logic unused_last;
    assign unused_last = last_i;

    always_comb begin
        win_o = REQ_SPI;
        if (!req0_i && req1_i) begin
            win_o = REQ_SEQ;
        end
    end
`endif

endmodule

// File: rtl/reg_arbiter.sv
// Two-requester register-bus arbiter: one access per grant, IDLE/ACCESS handshake, range checking.
// Define REG_ARB_RR_EN for round-robin arbitration (adds the last-grant pointer register).
module reg_arbiter
    import reg_arb_pkg::*;
#(
    parameter int unsigned           ADDR_W    = ADDR_W_DEF,
    parameter int unsigned           DATA_W    = DATA_W_DEF,
    parameter logic [ADDR_W-1:0]     LAST_ADDR = ADDR_W'(LAST_ADDR_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic              we0_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              gnt0_o,
    output logic              gnt1_o,
    output logic              rvalid0_o,
    output logic              rvalid1_o,
    output logic              err0_o,
    output logic              err1_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              read_o,
    output logic              write_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_write_o,
    input  logic [DATA_W-1:0] data_read_i
);

    logic [0:0]        state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic [1:0]        err_q, err_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_write_q, data_write_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              owner_q, owner_d;

    logic              any_req;
    logic              win;
    logic              last_grant;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign any_req   = req0_i | req1_i;
    assign sel_we    = (win == REQ_SEQ) ? we1_i    : we0_i;
    assign sel_addr  = (win == REQ_SEQ) ? addr1_i  : addr0_i;
    assign sel_wdata = (win == REQ_SEQ) ? wdata1_i : wdata0_i;

    reg_arb_pick u_pick (
        .req0_i (req0_i),
        .req1_i (req1_i),
        .last_i (last_grant),
        .win_o  (win)
    );

`ifdef REG_ARB_RR_EN
    logic last_q, last_d;

    // Pointer moves only when a grant is issued; reset value makes requester 0 win first.
    always_comb begin
        last_d = last_q;
        if (state_q == ST_IDLE && any_req) begin
            last_d = win;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= REQ_SEQ;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_grant = last_q;
`else
    assign last_grant = REQ_SEQ;
`endif

    // Next-state and registered-output decode.
    always_comb begin
        state_d      = state_q;
        gnt_d        = 2'b00;
        rvalid_d     = 2'b00;
        err_d        = 2'b00;
        read_d       = 1'b0;
        write_d      = 1'b0;
        addr_d       = addr_q;
        data_write_d = data_write_q;
        rdata_d      = rdata_q;
        owner_d      = owner_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d    = ST_ACCESS;
                    owner_d    = win;
                    gnt_d[win] = 1'b1;
                    if (sel_addr <= LAST_ADDR) begin
                        addr_d       = sel_addr;
                        data_write_d = sel_wdata;
                        read_d       = ~sel_we;
                        write_d      = sel_we;
                    end else begin
                        err_d[win] = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                state_d = ST_IDLE;
                if (read_q) begin
                    rdata_d           = data_read_i;
                    rvalid_d[owner_q] = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            gnt_q        <= 2'b00;
            rvalid_q     <= 2'b00;
            err_q        <= 2'b00;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            data_write_q <= '0;
            rdata_q      <= '0;
            owner_q      <= REQ_SPI;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            rvalid_q     <= rvalid_d;
            err_q        <= err_d;
            read_q       <= read_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            data_write_q <= data_write_d;
            rdata_q      <= rdata_d;
            owner_q      <= owner_d;
        end
    end

    assign gnt0_o       = gnt_q[REQ_SPI];
    assign gnt1_o       = gnt_q[REQ_SEQ];
    assign rvalid0_o    = rvalid_q[REQ_SPI];
    assign rvalid1_o    = rvalid_q[REQ_SEQ];
    assign err0_o       = err_q[REQ_SPI];
    assign err1_o       = err_q[REQ_SEQ];
    assign read_o       = read_q;
    assign write_o      = write_q;
    assign addr_o       = addr_q;
    assign data_write_o = data_write_q;
    assign rdata_o      = rdata_q;

endmodule

// File: tb/tb_reg_arbiter.sv
// Bench for reg_arbiter: directed scenarios plus random traffic against a transaction-timeline model.
module tb_reg_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       r_req [2];
    logic       r_we  [2];
    logic [5:0] r_addr[2];
    logic [7:0] r_wd  [2];
    logic [7:0] data_read_i;

    logic       gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, err0_o, err1_o;
    logic       read_o, write_o;
    logic [7:0] rdata_o, data_write_o;
    logic [5:0] addr_o;

    int checks   = 0;
    int failures = 0;

    // Model: cycle index of each sample, earliest edge a new grant may occur, pending read return.
    int         cyc;
    int         next_arb;
    int         rv_cyc;
    logic       rv_own;
    logic [7:0] rv_data;
    logic [7:0] m_rdata, m_dw;
    logic [5:0] m_addr;
    logic       m_last;
    logic       last_win;
    logic       seq_exp[3];

    reg_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_i       (r_req[0]),
        .req1_i       (r_req[1]),
        .we0_i        (r_we[0]),
        .we1_i        (r_we[1]),
        .addr0_i      (r_addr[0]),
        .addr1_i      (r_addr[1]),
        .wdata0_i     (r_wd[0]),
        .wdata1_i     (r_wd[1]),
        .gnt0_o       (gnt0_o),
        .gnt1_o       (gnt1_o),
        .rvalid0_o    (rvalid0_o),
        .rvalid1_o    (rvalid1_o),
        .err0_o       (err0_o),
        .err1_o       (err1_o),
        .rdata_o      (rdata_o),
        .read_o       (read_o),
        .write_o      (write_o),
        .addr_o       (addr_o),
        .data_write_o (data_write_o),
        .data_read_i  (data_read_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] pulses();
        return {gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, err0_o, err1_o, read_o, write_o};
    endfunction

    task automatic model_reset();
        next_arb = 0;
        rv_cyc   = -1;
        rv_own   = 1'b0;
        rv_data  = 8'h00;
        m_rdata  = 8'h00;
        m_dw     = 8'h00;
        m_addr   = 6'h00;
        m_last   = 1'b1;
    endtask

    task automatic set_req(input int r, input logic we, input logic [5:0] a, input logic [7:0] wd);
        r_req[r]  = 1'b1;
        r_we[r]   = we;
        r_addr[r] = a;
        r_wd[r]   = wd;
    endtask

    // One clock: predict this cycle's outputs, compare, then drive data_read for the cycle.
    // Expected pulse bits: gnt0 gnt1 rvalid0 rvalid1 err0 err1 read write.
    task automatic step(input logic [7:0] dr);
        logic [7:0] ep;
        logic       granted;
        logic       gw;
        @(posedge clk);
        cyc++;
        ep      = 8'h00;
        granted = 1'b0;
        gw      = 1'b0;
        if (rv_cyc == cyc) begin
            m_rdata = rv_data;
            ep[rv_own ? 4 : 5] = 1'b1;
        end
        if (cyc >= next_arb && (r_req[0] || r_req[1])) begin
            if (r_req[0] && r_req[1]) begin
`ifdef REG_ARB_RR_EN
                gw = ~m_last;
`else
                gw = 1'b0;
`endif
            end else begin
                gw = r_req[1];
            end
            m_last   = gw;
            last_win = gw;
            granted  = 1'b1;
            next_arb = cyc + 2;
            ep[gw ? 6 : 7] = 1'b1;
            if (r_addr[gw] <= 6'h1F) begin
                m_addr = r_addr[gw];
                m_dw   = r_wd[gw];
                if (r_we[gw]) begin
                    ep[0] = 1'b1;
                end else begin
                    ep[1]  = 1'b1;
                    rv_cyc = cyc + 1;
                    rv_own = gw;
                end
            end else begin
                ep[gw ? 2 : 3] = 1'b1;
            end
        end
        #1;
        check("pulses", 32'(pulses()), 32'(ep));
        check("addr", 32'(addr_o), 32'(m_addr));
        check("data_write", 32'(data_write_o), 32'(m_dw));
        check("rdata", 32'(rdata_o), 32'(m_rdata));
        if (granted) r_req[gw] = 1'b0;
        data_read_i = dr;
        if (ep[1]) rv_data = dr;
    endtask

    initial begin
        logic prev_low[2];
`ifdef REG_ARB_RR_EN
        seq_exp[0] = 1'b0; seq_exp[1] = 1'b1; seq_exp[2] = 1'b0;
`else
        seq_exp[0] = 1'b0; seq_exp[1] = 1'b0; seq_exp[2] = 1'b0;
`endif
        cyc = 0;
        last_win = 1'b0;
        model_reset();
        for (int r = 0; r < 2; r++) begin
            r_req[r] = 1'b0; r_we[r] = 1'b0; r_addr[r] = 6'h00; r_wd[r] = 8'h00;
        end
        data_read_i = 8'h00;
        rst_n = 1'b0;
        #12;
        check("reset_pulses", 32'(pulses()), 32'h0);
        check("reset_addr", 32'(addr_o), 32'h0);
        check("reset_dwr", 32'(data_write_o), 32'h0);
        check("reset_rdata", 32'(rdata_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(8'h00);

        // Single write from requester 0.
        set_req(0, 1'b1, 6'h03, 8'hA5);
        step(8'h00);
        check("wr_strobe", 32'(write_o), 32'h1);
        step(8'h00);
        step(8'h00);
        check("wr_no_rvalid", 32'(rvalid0_o), 32'h0);

        // Read from requester 1 with data returned during ACCESS.
        set_req(1, 1'b0, 6'h05, 8'h00);
        step(8'h3C);
        step(8'h00);
        check("rd_rvalid1", 32'(rvalid1_o), 32'h1);
        check("rd_rdata", 32'(rdata_o), 32'h3C);
        step(8'h00);

        // Three back-to-back collisions.
        for (int i = 0; i < 3; i++) begin
            set_req(0, 1'b1, 6'(8 + i), 8'(8'h10 + i));
            if (!r_req[1]) set_req(1, 1'b1, 6'(16 + i), 8'(8'h20 + i));
            step(8'h00);
            check("collide_gnt1", 32'(gnt1_o), 32'(seq_exp[i]));
            step(8'h00);
        end
        repeat (4) step(8'h00);

        // Out-of-range read: error pulse, no strobe, rdata untouched.
        set_req(0, 1'b0, 6'h20, 8'h00);
        step(8'h77);
        check("oor_err0", 32'(err0_o), 32'h1);
        check("oor_read", 32'(read_o), 32'h0);
        step(8'h00);
        check("oor_rdata", 32'(rdata_o), 32'h3C);
        step(8'h00);

        // Reset in the middle of a write access.
        set_req(0, 1'b1, 6'h07, 8'h5A);
        step(8'h00);
        check("pre_rst_write", 32'(write_o), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_write", 32'(write_o), 32'h0);
        check("rst_pulses", 32'(pulses()), 32'h0);
        check("rst_addr", 32'(addr_o), 32'h0);
        model_reset();
        for (int r = 0; r < 2; r++) r_req[r] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(8'(($urandom)));

        // Random traffic; a requester stays low for at least one cycle after being granted.
        prev_low[0] = 1'b1;
        prev_low[1] = 1'b1;
        for (int i = 0; i < 600; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (!r_req[r] && prev_low[r] && $urandom_range(0, 2) == 0) begin
                    set_req(r, 1'($urandom_range(0, 1)),
                            ($urandom_range(0, 3) == 0) ? 6'($urandom_range(32, 63))
                                                        : 6'($urandom_range(0, 31)),
                            8'($urandom));
                end
                prev_low[r] = !r_req[r];
            end
            step(8'($urandom));
        end
        for (int r = 0; r < 2; r++) r_req[r] = 1'b0;
        repeat (3) step(8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
